// File: rtl/down_timer_pkg.sv
// Shared definitions for the counter blocks: the timer FSM state encoding.
package down_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/down_timer.sv
// Loadable down timer: counts qualified ticks to zero, then stops (one-shot)
// or reloads (periodic). All outputs are registered.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state;
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
            expired    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count      <= load_val;
                reload_reg <= load_val;
                state      <= IDLE;
                busy       <= 1'b0;
                expired    <= 1'b0;
            end else if (stop && state == RUN) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start && state != RUN) begin
                count   <= reload_reg;
                expired <= 1'b0;
                if (reload_reg != ZERO) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else if (auto_reload) begin
                    // zero period: every enabled tick is a terminal count
                    state <= RUN;
                    busy  <= 1'b1;
                    tc    <= 1'b1;
                end else begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    expired <= 1'b1;
                    tc      <= 1'b1;
                end
            end else if (state == RUN && en) begin
                if (count > ONE) begin
                    count <= count - ONE;
                end else if (count == ONE) begin
                    count <= ZERO;
                    tc    <= 1'b1;
                    if (!auto_reload) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        expired <= 1'b1;
                    end
                end else if (auto_reload) begin
                    count <= reload_reg;
                    tc    <= (reload_reg == ZERO);
                end else begin
                    // periodic mode dropped while parked at zero: finish quietly
                    state   <= DONE;
                    busy    <= 1'b0;
                    expired <= 1'b1;
                end
            end
        end
    end

endmodule
